// File: rtl/rd_port_arbiter.sv
// Round-robin arbiter sharing the async FIFO read port between N_REQ consumers.
// A consumer is granted for at most BURST_LEN pops. The FIFO pop strobe follows
// the owner's request and the empty flag. Each popped word is registered and
// presented together with the owner's index.
module rd_port_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]      gnt,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_WIDTH-1:0]   out_id
);

    localparam int unsigned CntW = $clog2(BURST_LEN) + 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                state_q, state_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]   gidx_q, gidx_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;

    logic [ID_WIDTH-1:0]   sel;
    logic                  sel_found;
    logic                  owner_req;
    logic                  pop;
    logic                  burst_done;
    logic                  leave;

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    // Circular priority scan: first set request at or above rr_ptr, wrapping
    always_comb begin
        int unsigned idx;
        logic [ID_WIDTH-1:0] idx_w;
        sel       = rr_ptr_q;
        sel_found = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx   = (32'(rr_ptr_q) + i) % N_REQ;
            idx_w = ID_WIDTH'(idx);
            if (!sel_found && req[idx_w]) begin
                sel       = idx_w;
                sel_found = 1'b1;
            end
        end
    end

    // Pop and burst-exit decode; only the owner's request can cause a pop
    always_comb begin
        owner_req  = |(req & gnt_q);
        pop        = (state_q == StGrant) && owner_req && !rempty;
        burst_done = pop && (cnt_q == CntW'(BURST_LEN - 1));
        leave      = (state_q == StGrant) && (burst_done || !owner_req);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (|req) state_d = StGrant;
            StGrant: if (leave) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Grant, burst counter, round-robin pointer and output capture next values
    always_comb begin
        gnt_d       = gnt_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        if (state_q == StIdle && |req) begin
            gnt_d  = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
            gidx_d = sel;
            cnt_d  = '0;
        end
        if (pop) begin
            cnt_d       = cnt_q + 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = rdata;
            out_id_d    = gidx_q;
        end
        if (leave) begin
            gnt_d    = '0;
            cnt_d    = '0;
            rr_ptr_d = (gidx_q == ID_WIDTH'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
    end

    // Outputs; rinc is combinational so the pop lands in the same cycle
    always_comb begin
        gnt       = gnt_q;
        rinc      = pop;
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_id    = out_id_q;
    end

endmodule

// File: doc/rd_port_arbiter.md
Name: rd_port_arbiter

Overview:
Round-robin arbiter that shares the single read port of the async FIFO between N consumers in the read clock domain. It grants one consumer at a time for a bounded burst and drives the FIFO read-increment from that consumer's request and the FIFO empty flag. It captures the popped word and presents it with the consumer ID. It sits between the FIFO read-side controller and the consumer logic.

Parameters:
N_REQ, 4, number of consumers (>=2)
BURST_LEN, 4, maximum words popped per grant (>=1)
DATA_WIDTH, 8, FIFO word width
ID_WIDTH, 2, consumer ID width, must equal clog2(N_REQ)

Ports:
r_clk  input  1  read-domain clock
r_rst  input  1  reset, asynchronous, active-low
req  input  N_REQ  per-consumer request; high = consumer wants/accepts a word this cycle
gnt  output  N_REQ  one-hot registered grant
rempty  input  1  FIFO empty flag from read controller
rdata  input  DATA_WIDTH  FIFO memory read data at current raddr (combinational)
rinc  output  1  FIFO pop strobe
out_valid  output  1  registered pulse, one per popped word
out_data  output  DATA_WIDTH  popped word
out_id  output  ID_WIDTH  index of consumer owning out_data

Behaviour:
- Reset (async, r_rst=0): state=IDLE, gnt=0, rinc=0, out_valid=0, out_data=0, out_id=0, rr_ptr=0, burst count=0.
- States: IDLE, GRANT.
- IDLE: if req!=0, select first set req bit scanning circularly from rr_ptr upward (wrap N_REQ-1 -> 0); next cycle gnt=one-hot(sel), cnt=0, state=GRANT. If req==0, stay IDLE with gnt=0.
- GRANT, pop condition: pop = |(req & gnt) & ~rempty. rinc = pop, combinational, same cycle. gnt never changes within a cycle.
- Each pop: cnt<=cnt+1; next cycle out_valid=1, out_data=rdata sampled in the pop cycle, out_id=granted index. Otherwise out_valid=0 next cycle; out_data/out_id hold.
- Exit GRANT to IDLE when either:
  - a pop occurs with cnt==BURST_LEN-1 (burst complete), or
  - the granted consumer's req is low (no pop that cycle).
- On exit: gnt<=0, rr_ptr<=(granted index+1) mod N_REQ, cnt<=0.
- FIFO empty while granted (req high, rempty=1): hold grant, no pop, cnt unchanged. No timeout.
- Turnaround: one IDLE cycle between bursts, so throughput is at most BURST_LEN words per BURST_LEN+1 cycles under contention. Grant latency from IDLE with req set: gnt asserted 1 cycle later.
- Requests arriving mid-burst are not considered until IDLE. Non-granted req bits never cause rinc.
- rinc is never high when rempty=1 or gnt=0.
- Mid-operation reset: all state returns to reset values immediately; in-flight out_valid is dropped.
- cnt width is clog2(BURST_LEN)+1; it never exceeds BURST_LEN-1.

Test Plan:
- Reset, then req=4'b0001, FIFO holds 6 words A0..A5 -> gnt=0001 one cycle after req; rinc high 4 consecutive cycles; out_valid pulses with A0..A3 and out_id=0; gnt=0 for 1 cycle; regrant with A4, A5 popped.
- req=4'b1111 held high, FIFO never empty, BURST_LEN=4 -> grants cycle in order 0,1,2,3,0; each burst has 4 pops; one idle cycle between bursts; out_id tracks the grant.
- Grant to consumer 2, consumer 2 drops req after 2 pops while req[3]=1 -> exit to IDLE; rr_ptr=3; next gnt=1000.
- Granted with FIFO empty for 5 cycles, then 1 word written -> rinc=0 and gnt held during the empty cycles; a single pop when rempty falls; out_valid one cycle after the pop.
- Assert r_rst low mid-burst at cnt=2 -> gnt, rinc, and out_valid are 0 immediately; after release, arbitration restarts from rr_ptr=0.
- req=4'b1010 with rr_ptr=2 -> consumer 3 granted first, then consumer 1 (wrap-around scan).
